// File: rtl/instr_mem_loader.sv
// Instruction memory, boot-loaded from a UART byte stream: LSB-first 32-bit count, then words (optional checksum via INSTR_MEM_CHECKSUM_EN).
// Latency: one cycle from fetch address to instruction; reads return NOP until the load has finished.
// Backpressure: none; one byte per cycle is accepted whenever rx_valid is high, and bytes are ignored once loading is done.
module instr_mem_loader #(
    parameter int          ADDR_WIDTH = 15,
    parameter logic [31:0] NOP        = 32'hf0000000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [31:0]           instr_mem_addr,
    output logic [31:0]           instr_mem_instr,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  boot_done,
    output logic                  load_err,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    // Depth widened to 33 bits so the declared count can be compared without wrap.
    localparam logic [32:0] DEPTH_W = 33'd1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] WPTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_HEADER = 2'd0,
        ST_LOAD   = 2'd1,
`ifdef INSTR_MEM_CHECKSUM_EN
        ST_CHECK  = 2'd2,
`endif
        ST_DONE   = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            idx_q, idx_d;
    logic [23:0]           asm_q, asm_d;      // {b2,b1,b0} of the field in progress
    logic [31:0]           count_q, count_d;  // declared word count N
    logic [31:0]           wcnt_q, wcnt_d;    // words received so far, including discarded ones
    logic [ADDR_WIDTH:0]   wptr_q, wptr_d;    // words actually written, saturates at depth
    logic                  err_q, err_d;
`ifdef INSTR_MEM_CHECKSUM_EN
    logic [31:0]           sum_q, sum_d;
`endif
    logic [31:0]           instr_q;

    logic [31:0]           word;
    logic                  field_done;
    logic                  mem_we;
    logic                  addr_in_range;

    logic [31:0] mem [0:(1 << ADDR_WIDTH) - 1];

    assign word          = {rx_data, asm_q};
    assign field_done    = rx_valid && (idx_q == 2'd3) && (state_q != ST_DONE);
    assign addr_in_range = (instr_mem_addr[31:ADDR_WIDTH] == '0);

    // Next-state logic: byte assembly, field decode and load bookkeeping.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        asm_d   = asm_q;
        count_d = count_q;
        wcnt_d  = wcnt_q;
        wptr_d  = wptr_q;
        err_d   = err_q;
`ifdef INSTR_MEM_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        mem_we  = 1'b0;

        if (rx_valid && (state_q != ST_DONE)) begin
            idx_d = idx_q + 2'd1;
            asm_d = {rx_data, asm_q[23:8]};
        end

        case (state_q)
            ST_HEADER: begin
                if (field_done) begin
                    count_d = word;
                    wcnt_d  = '0;
                    if ({1'b0, word} > DEPTH_W) begin
                        err_d = 1'b1;
                    end
                    if (word == 32'd0) begin
`ifdef INSTR_MEM_CHECKSUM_EN
                        state_d = ST_CHECK;
`else
                        state_d = ST_DONE;
`endif
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (field_done) begin
                    wcnt_d = wcnt_q + 32'd1;
`ifdef INSTR_MEM_CHECKSUM_EN
                    sum_d  = sum_q + word;
`endif
                    // Words beyond the array are counted but dropped.
                    if (!wptr_q[ADDR_WIDTH]) begin
                        mem_we = 1'b1;
                        wptr_d = wptr_q + WPTR_ONE;
                    end
                    if ((wcnt_q + 32'd1) == count_q) begin
`ifdef INSTR_MEM_CHECKSUM_EN
                        state_d = ST_CHECK;
`else
                        state_d = ST_DONE;
`endif
                    end
                end
            end
`ifdef INSTR_MEM_CHECKSUM_EN
            ST_CHECK: begin
                if (field_done) begin
                    state_d = ST_DONE;
                    if (word != sum_q) begin
                        err_d = 1'b1;
                    end
                end
            end
`endif
            default: ;
        endcase
    end

    // Control state registers; a reset mid-load restarts from the header.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_HEADER;
            idx_q   <= 2'd0;
            asm_q   <= '0;
            count_q <= '0;
            wcnt_q  <= '0;
            wptr_q  <= '0;
            err_q   <= 1'b0;
`ifdef INSTR_MEM_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            asm_q   <= asm_d;
            count_q <= count_d;
            wcnt_q  <= wcnt_d;
            wptr_q  <= wptr_d;
            err_q   <= err_d;
`ifdef INSTR_MEM_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    // Memory write port; contents survive reset so the array maps onto block RAM.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[wptr_q[ADDR_WIDTH-1:0]] <= word;
        end
    end

    // Registered fetch read; NOP until loaded or when the address is out of range.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            instr_q <= NOP;
        end else if ((state_q == ST_DONE) && addr_in_range) begin
            instr_q <= mem[instr_mem_addr[ADDR_WIDTH-1:0]];
        end else begin
            instr_q <= NOP;
        end
    end

    assign instr_mem_instr = instr_q;
    assign boot_done       = (state_q == ST_DONE);
    assign load_err        = err_q;
    assign words_loaded    = wptr_q;

endmodule
